// File: rtl/fifo_pkg.sv
// Shared types for the fifo unloader: drain FSM states and remaining-count width helper.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // remaining must be able to hold the full DEPTH value, not just DEPTH-1.
  function automatic int rem_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_REM_W = rem_width(DEFAULT_DEPTH);

endpackage

// File: rtl/fifo_unloader.sv
// Parallel-capture, serial-drain unloader: snapshots DEPTH entries and streams them oldest-first.
// Optional q_last output is enabled by defining FIFO_UNLOADER_LAST_EN.
module fifo_unloader
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  output logic                          load_ready,
  input  logic [DEPTH*BITS-1:0]         d_par,
  input  logic                          flush,
  output logic [BITS-1:0]               q,
  output logic                          q_valid,
  input  logic                          q_ready,
  output logic [rem_width(DEPTH)-1:0]   remaining,
`ifdef FIFO_UNLOADER_LAST_EN
  output logic                          q_last,
`endif
  output logic                          done
);

  localparam int RW = rem_width(DEPTH);
  localparam int HW = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where q_valid=1 and q_ready=1;
  // q_valid never depends on q_ready, and q holds steady until the transfer.

  state_e          state_q, state_d;
  logic [HW-1:0]   head_q, head_d;
  logic [RW-1:0]   remaining_q, remaining_d;
  logic            done_q, done_d;
  logic [BITS-1:0] storage_q [DEPTH];
  logic [BITS-1:0] storage_d [DEPTH];

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    storage_d   = storage_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          for (int i = 0; i < DEPTH; i++) begin
            storage_d[i] = d_par[i*BITS +: BITS];
          end
          head_d      = '0;
          remaining_d = RW'(DEPTH);
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // flush discards a same-cycle transfer and never raises done.
        if (flush) begin
          state_d     = IDLE;
          head_d      = '0;
          remaining_d = '0;
        end else if (q_ready) begin
          if (remaining_q == RW'(1)) begin
            state_d     = IDLE;
            head_d      = '0;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            head_d      = head_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      storage_q   <= storage_d;
    end
  end

  assign q_valid    = (state_q == DRAIN);
  assign load_ready = (state_q == IDLE);
  assign q          = storage_q[head_q];
  assign remaining  = remaining_q;
  assign done       = done_q;
`ifdef FIFO_UNLOADER_LAST_EN
  assign q_last     = (state_q == DRAIN) && (remaining_q == RW'(1));
`endif

endmodule
